// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared realigner control types and address generator config/state types
package hwpe_stream_package;

  localparam int unsigned REALIGN_ADDR_W = 32;
  localparam int unsigned REALIGN_LEN_W  = 16;

  // Per-word control consumed by the source realigner
  typedef struct packed {
    logic                     enable;
    logic                     strb_valid;
    logic                     realign;
    logic                     first;
    logic                     last;
    logic                     last_packet;
    logic [REALIGN_LEN_W-1:0] line_length;
  } ctrl_realign_t;

  // Transfer configuration latched on start
  typedef struct packed {
    logic [REALIGN_ADDR_W-1:0] base;
    logic [REALIGN_LEN_W-1:0]  line_bytes;
    logic [REALIGN_ADDR_W-1:0] stride;
    logic [REALIGN_LEN_W-1:0]  nb_lines;
  } realign_addrgen_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } realign_addrgen_state_t;

endpackage

// File: rtl/hwpe_stream_realign_strbgen.sv
// rtl/hwpe_stream_realign_strbgen.sv - combinational strobe of one word of a possibly misaligned line
module hwpe_stream_realign_strbgen #(
  parameter int unsigned B    = 4,
  parameter int unsigned OFFS = 2
) (
  input  logic [OFFS-1:0] m_i,
  input  logic            realign_i,
  input  logic            first_i,
  input  logic            last_i,
  output logic [B-1:0]    strb_o
);

  logic [B-1:0] low_mask;

  // Misaligned lines keep the upper bytes of the head word and the lower bytes of the tail word
  always_comb begin
    low_mask = (B'(1) << m_i) - B'(1);
    strb_o   = '1;
    if (realign_i) begin
      if (first_i) begin
        strb_o = ~low_mask;
      end else if (last_i) begin
        strb_o = low_mask;
      end
    end
  end

endmodule

// File: rtl/hwpe_stream_realign_addressgen.sv
// rtl/hwpe_stream_realign_addressgen.sv - 2D word-aligned load address walker feeding the source realigner (option: HWPE_STREAM_REALIGN_ADDRGEN_STALL_EN)
module hwpe_stream_realign_addressgen
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  line_bytes_i,
  input  logic [ADDR_WIDTH-1:0] line_stride_i,
  input  logic [LEN_WIDTH-1:0]  nb_lines_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output ctrl_realign_t         ctrl_o,
`ifdef HWPE_STREAM_REALIGN_ADDRGEN_STALL_EN
  input  logic                  decoupled_stall_i,
`endif
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned B    = DATA_WIDTH / 8;
  localparam int unsigned OFFS = $clog2(B);
  localparam int unsigned WW   = LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(B - 1);

  realign_addrgen_state_t state_q, state_d;
  realign_addrgen_cfg_t   cfg_q, cfg_d;
  logic [WW-1:0]          word_q, word_d;
  logic [LEN_WIDTH-1:0]   line_q, line_d;
  logic [ADDR_WIDTH-1:0]  line_base_q, line_base_d;

  logic                   advance;
  logic                   run;
  logic                   handshake;
  logic [OFFS-1:0]        m;
  logic                   realign;
  logic [LEN_WIDTH-1:0]   line_len;
  logic [WW-1:0]          last_word;
  logic                   is_first;
  logic                   is_last;
  logic                   is_last_line;
  logic [B-1:0]           word_strb;

`ifdef HWPE_STREAM_REALIGN_ADDRGEN_STALL_EN
  assign advance = enable_i & ~decoupled_stall_i;
`else
  assign advance = enable_i;
`endif

  // Static per-transfer geometry derived from the latched configuration
  assign m            = cfg_q.base[OFFS-1:0];
  assign realign      = (m != '0);
  assign line_len     = LEN_WIDTH'(cfg_q.line_bytes >> OFFS);
  assign last_word    = ({1'b0, line_len} + WW'(realign)) - WW'(1);
  assign is_first     = (word_q == '0);
  assign is_last      = (word_q == last_word);
  assign is_last_line = (line_q == (LEN_WIDTH'(cfg_q.nb_lines) - LEN_WIDTH'(1)));

  assign run          = (state_q == RUN);
  assign addr_valid_o = run & advance;
  assign handshake    = addr_valid_o & addr_ready_i;
  assign busy_o       = run;
  assign done_o       = (state_q == DONE);

  hwpe_stream_realign_strbgen #(
    .B    (B),
    .OFFS (OFFS)
  ) i_strbgen (
    .m_i       (m),
    .realign_i (realign),
    .first_i   (is_first),
    .last_i    (is_last),
    .strb_o    (word_strb)
  );

  // Request outputs: idle values outside RUN so reset/clear are visible at once
  always_comb begin
    addr_o = '0;
    strb_o = '1;
    ctrl_o = '0;
    if (run) begin
      addr_o             = (line_base_q & ALIGN_MASK) + (ADDR_WIDTH'(word_q) << OFFS);
      strb_o             = word_strb;
      ctrl_o.enable      = 1'b1;
      ctrl_o.strb_valid  = handshake;
      ctrl_o.realign     = realign;
      ctrl_o.first       = is_first;
      ctrl_o.last        = is_last;
      ctrl_o.last_packet = is_last & is_last_line;
      ctrl_o.line_length = REALIGN_LEN_W'(line_len);
    end
  end

  // Next-state: clear wins, then enable/stall freeze, then start or word/line stepping
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    word_d      = word_q;
    line_d      = line_q;
    line_base_d = line_base_q;
    if (clear_i) begin
      state_d = IDLE;
      word_d  = '0;
      line_d  = '0;
    end else if (advance) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cfg_d.base       = REALIGN_ADDR_W'(base_addr_i);
            cfg_d.line_bytes = REALIGN_LEN_W'(line_bytes_i);
            cfg_d.stride     = REALIGN_ADDR_W'(line_stride_i);
            cfg_d.nb_lines   = REALIGN_LEN_W'(nb_lines_i);
            word_d           = '0;
            line_d           = '0;
            line_base_d      = base_addr_i;
            if ((nb_lines_i != '0) && (line_bytes_i != '0)) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
            end
          end
        end
        RUN: begin
          if (handshake) begin
            if (is_last) begin
              word_d = '0;
              if (is_last_line) begin
                state_d = DONE;
              end else begin
                line_d      = line_q + LEN_WIDTH'(1);
                line_base_d = line_base_q + ADDR_WIDTH'(cfg_q.stride);
              end
            end else begin
              word_d = word_q + WW'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      word_q      <= '0;
      line_q      <= '0;
      line_base_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      word_q      <= word_d;
      line_q      <= line_d;
      line_base_q <= line_base_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_realign_addressgen.sv
// tb/tb_hwpe_stream_realign_addressgen.sv - directed self-checking bench for the realign address generator
module tb_hwpe_stream_realign_addressgen;
  import hwpe_stream_package::*;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        enable;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] line_bytes;
  logic [31:0] line_stride;
  logic [15:0] nb_lines;
  logic [31:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic [3:0]  strb;
  ctrl_realign_t ctrl;
  logic        decoupled_stall;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  logic [31:0] ea  [8];
  logic [3:0]  es  [8];
  logic [2:0]  eflp[8];

  hwpe_stream_realign_addressgen #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .LEN_WIDTH  (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .enable_i      (enable),
    .start_i       (start),
    .base_addr_i   (base_addr),
    .line_bytes_i  (line_bytes),
    .line_stride_i (line_stride),
    .nb_lines_i    (nb_lines),
    .addr_o        (addr),
    .addr_valid_o  (addr_valid),
    .addr_ready_i  (addr_ready),
    .strb_o        (strb),
    .ctrl_o        (ctrl),
`ifdef HWPE_STREAM_REALIGN_ADDRGEN_STALL_EN
    .decoupled_stall_i (decoupled_stall),
`endif
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_aligned();
    ea[0] = 32'h100; ea[1] = 32'h104; ea[2] = 32'h108; ea[3] = 32'h10C;
    for (int i = 0; i < 4; i++) es[i] = 4'hF;
    eflp[0] = 3'b100; eflp[1] = 3'b000; eflp[2] = 3'b000; eflp[3] = 3'b011;
  endtask

  task automatic load_misaligned();
    ea[0] = 32'h100; ea[1] = 32'h104; ea[2] = 32'h108;
    ea[3] = 32'h140; ea[4] = 32'h144; ea[5] = 32'h148;
    es[0] = 4'hE; es[1] = 4'hF; es[2] = 4'h1;
    es[3] = 4'hE; es[4] = 4'hF; es[5] = 4'h1;
    eflp[0] = 3'b100; eflp[1] = 3'b000; eflp[2] = 3'b010;
    eflp[3] = 3'b100; eflp[4] = 3'b000; eflp[5] = 3'b011;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; enable = 1'b1; start = 1'b0; addr_ready = 1'b1;
    decoupled_stall = 1'b0;
    base_addr = '0; line_bytes = '0; line_stride = '0; nb_lines = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({addr_valid, addr, strb, ctrl, busy, done} !== {1'b0, 32'h0, 4'hF, 22'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs got valid=%b addr=%h strb=%h ctrl=%h busy=%b done=%b expected 0/0/f/0/0/0",
               addr_valid, addr, strb, ctrl, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({addr_valid, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset got valid=%b busy=%b done=%b expected 000", addr_valid, busy, done);
    end
  endtask

  // hold_mode: 0 = grant low, 1 = enable low, 2 = decoupled stall
  task automatic test_seq(input string name, input logic [31:0] b, input logic [15:0] lb,
                          input logic [31:0] st, input logic [15:0] nl, input int n,
                          input logic exp_realign, input logic [15:0] exp_ll,
                          input int hold_word, input int hold_cycles, input int hold_mode);
    logic [60:0] got, exp;
    base_addr = b; line_bytes = lb; line_stride = st; nb_lines = nl;
    addr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == hold_word) begin
        for (int h = 0; h < hold_cycles; h++) begin
          if (hold_mode == 0) addr_ready = 1'b0;
          else if (hold_mode == 1) enable = 1'b0;
          else decoupled_stall = 1'b1;
          #1;
          got = {addr_valid, addr, strb, ctrl.enable, ctrl.strb_valid, ctrl.realign,
                 ctrl.first, ctrl.last, ctrl.last_packet, ctrl.line_length, busy};
          exp = {(hold_mode == 0), ea[i], es[i], 1'b1, 1'b0, exp_realign,
                 eflp[i], exp_ll, 1'b1};
          tests++;
          if (got !== exp) begin
            fails++;
            $display("FAIL %s_hold_w%0d_c%0d got %h expected %h", name, i, h, got, exp);
          end
          @(negedge clk);
        end
        addr_ready = 1'b1; enable = 1'b1; decoupled_stall = 1'b0;
      end
      #1;
      got = {addr_valid, addr, strb, ctrl.enable, ctrl.strb_valid, ctrl.realign,
             ctrl.first, ctrl.last, ctrl.last_packet, ctrl.line_length, busy};
      exp = {1'b1, ea[i], es[i], 1'b1, 1'b1, exp_realign, eflp[i], exp_ll, 1'b1};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s_word%0d got %h expected %h", name, i, got, exp);
      end
      @(negedge clk);
    end
    tests++;
    if ({done, busy, addr_valid} !== 3'b100) begin
      fails++;
      $display("FAIL %s_done got done=%b busy=%b valid=%b expected 1/0/0", name, done, busy, addr_valid);
    end
    @(negedge clk);
    tests++;
    if ({done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL %s_done_pulse got done=%b busy=%b expected 0/0", name, done, busy);
    end
  endtask

  task automatic test_zero_lines();
    base_addr = 32'h200; line_bytes = 16'd16; line_stride = 32'h40; nb_lines = 16'd0;
    start = 1'b1;
    #1;
    tests++;
    if ({addr_valid, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL zero_lines_start got valid=%b busy=%b done=%b expected 000", addr_valid, busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({addr_valid, busy, done} !== 3'b001) begin
      fails++;
      $display("FAIL zero_lines_done got valid=%b busy=%b done=%b expected 001", addr_valid, busy, done);
    end
    @(negedge clk);
    tests++;
    if ({addr_valid, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL zero_lines_after got valid=%b busy=%b done=%b expected 000", addr_valid, busy, done);
    end
  endtask

  task automatic test_clear();
    base_addr = 32'h101; line_bytes = 16'd8; line_stride = 32'h40; nb_lines = 16'd2;
    addr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({addr_valid, addr} !== {1'b1, 32'h108}) begin
      fails++;
      $display("FAIL clear_pre got valid=%b addr=%h expected 1/00000108", addr_valid, addr);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if ({addr_valid, busy, done, addr} !== {3'b000, 32'h0}) begin
      fails++;
      $display("FAIL clear_idle got valid=%b busy=%b done=%b addr=%h expected 0/0/0/0", addr_valid, busy, done, addr);
    end
    @(negedge clk);
    tests++;
    if ({addr_valid, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL clear_no_done got valid=%b busy=%b done=%b expected 000", addr_valid, busy, done);
    end
    load_misaligned();
    test_seq("replay", 32'h101, 16'd8, 32'h40, 16'd2, 6, 1'b1, 16'd2, -1, 0, 0);
  endtask

  task automatic test_async_reset();
    base_addr = 32'h101; line_bytes = 16'd8; line_stride = 32'h40; nb_lines = 16'd2;
    addr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({addr_valid, addr, strb, ctrl, busy, done} !== {1'b0, 32'h0, 4'hF, 22'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset got valid=%b addr=%h strb=%h ctrl=%h busy=%b done=%b expected 0/0/f/0/0/0",
               addr_valid, addr, strb, ctrl, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    load_aligned();
    test_seq("aligned", 32'h100, 16'd16, 32'h0, 16'd1, 4, 1'b0, 16'd4, -1, 0, 0);
    load_misaligned();
    test_seq("misaligned", 32'h101, 16'd8, 32'h40, 16'd2, 6, 1'b1, 16'd2, -1, 0, 0);
    test_seq("backpressure", 32'h101, 16'd8, 32'h40, 16'd2, 6, 1'b1, 16'd2, 1, 3, 0);
    test_seq("freeze", 32'h101, 16'd8, 32'h40, 16'd2, 6, 1'b1, 16'd2, 4, 2, 1);
    test_zero_lines();
    test_clear();
    test_async_reset();
`ifdef HWPE_STREAM_REALIGN_ADDRGEN_STALL_EN
    load_misaligned();
    test_seq("stall", 32'h101, 16'd8, 32'h40, 16'd2, 6, 1'b1, 16'd2, 2, 2, 2);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
